load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU.
- Consumes the ALU's address output (effective address rs1+imm) and rs2 store data, decoded by funct3.
- Drives a single-outstanding valid/ready memory port; performs byte-lane steering and store strobes, and load alignment with sign/zero extension.
- Flags misaligned, illegal or timed-out accesses to the control unit.

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU effective address and rs2 data, issues one
// memory access at a time over a valid/ready port, steers store lanes,
// aligns/extends load data and reports misaligned, illegal or timed-out accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_MISAL = 2'd1;
  localparam logic [1:0] C_ILLEG = 2'd2;
  localparam logic [1:0] C_TMO   = 2'd3;

  logic [1:0]       r_state, w_state;
  logic             r_req_valid, w_req_valid;
  logic [31:0]      r_addr, w_addr;
  logic             r_we, w_we;
  logic [3:0]       r_wstrb, w_wstrb;
  logic [31:0]      r_wdata, w_wdata;
  logic [31:0]      r_rdata, w_rdata;
  logic             r_done, w_done;
  logic             r_fault, w_fault;
  logic [1:0]       r_cause, w_cause;
  logic             r_busy, w_busy;
  logic [2:0]       r_funct3, w_funct3;
  logic [1:0]       r_off, w_off;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic             w_illegal;
  logic             w_misal;
  logic [3:0]       w_st_strb;
  logic [31:0]      w_st_data;
  logic [31:0]      w_rsh;
  logic [31:0]      w_ld_data;
  logic             w_tmo;

  // Decode an incoming request: legality, alignment and store lane steering.
  always_comb begin
    w_illegal = is_store ? (funct3 >= 3'd3)
                         : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    w_misal   = (funct3[1:0] == 2'd1 && addr[0]) ||
                (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    case (funct3[1:0])
      2'd0: begin
        w_st_strb = 4'b0001 << addr[1:0];
        w_st_data = {4{wdata[7:0]}};
      end
      2'd1: begin
        w_st_strb = 4'b0011 << addr[1:0];
        w_st_data = {2{wdata[15:0]}};
      end
      default: begin
        w_st_strb = 4'b1111;
        w_st_data = wdata;
      end
    endcase
  end

  // Align the returned word to the addressed lane and extend per funct3.
  always_comb begin
    w_rsh = mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'd0:    w_ld_data = {{24{w_rsh[7]}}, w_rsh[7:0]};
      3'd1:    w_ld_data = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'd4:    w_ld_data = {24'd0, w_rsh[7:0]};
      3'd5:    w_ld_data = {16'd0, w_rsh[15:0]};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Timeout fires on the cycle the access would reach TIMEOUT cycles outstanding.
  assign w_tmo = (TIMEOUT != 0) && ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_req_valid = r_req_valid;
    w_addr      = r_addr;
    w_we        = r_we;
    w_wstrb     = r_wstrb;
    w_wdata     = r_wdata;
    w_rdata     = r_rdata;
    w_done      = 1'b0;
    w_fault     = 1'b0;
    w_cause     = r_cause;
    w_funct3    = r_funct3;
    w_off       = r_off;
    w_cnt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_funct3 = funct3;
          w_off    = addr[1:0];
          if (w_illegal) begin
            w_state = S_FIN;
            w_done  = 1'b1;
            w_fault = 1'b1;
            w_cause = C_ILLEG;
          end else if (w_misal) begin
            w_state = S_FIN;
            w_done  = 1'b1;
            w_fault = 1'b1;
            w_cause = C_MISAL;
          end else begin
            w_state     = S_REQ;
            w_req_valid = 1'b1;
            w_addr      = {addr[31:2], 2'b00};
            w_we        = is_store;
            w_wstrb     = is_store ? w_st_strb : 4'b0000;
            w_wdata     = is_store ? w_st_data : r_wdata;
            w_cnt       = '0;
          end
        end
      end

      S_REQ: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (mem_req_ready || w_tmo) begin
          w_req_valid = 1'b0;
          w_we        = 1'b0;
          w_wstrb     = 4'b0000;
        end
        if (mem_req_ready && r_we) begin
          w_state = S_FIN;
          w_done  = 1'b1;
          w_cause = C_NONE;
        end else if (w_tmo) begin
          w_state = S_FIN;
          w_done  = 1'b1;
          w_fault = 1'b1;
          w_cause = C_TMO;
        end else if (mem_req_ready) begin
          w_state = S_WAIT;
        end
      end

      S_WAIT: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (mem_rsp_valid) begin
          w_state = S_FIN;
          w_rdata = w_ld_data;
          w_done  = 1'b1;
          w_cause = C_NONE;
        end else if (w_tmo) begin
          w_state = S_FIN;
          w_done  = 1'b1;
          w_fault = 1'b1;
          w_cause = C_TMO;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_cause     <= C_NONE;
      r_busy      <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_req_valid <= w_req_valid;
      r_addr      <= w_addr;
      r_we        <= w_we;
      r_wstrb     <= w_wstrb;
      r_wdata     <= w_wdata;
      r_rdata     <= w_rdata;
      r_done      <= w_done;
      r_fault     <= w_fault;
      r_cause     <= w_cause;
      r_busy      <= w_busy;
      r_funct3    <= w_funct3;
      r_off       <= w_off;
      r_cnt       <= w_cnt;
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_addr      = r_addr;
  assign mem_we        = r_we;
  assign mem_wstrb     = r_wstrb;
  assign mem_wdata     = r_wdata;
  assign rdata         = r_rdata;
  assign done          = r_done;
  assign fault         = r_fault;
  assign fault_cause   = r_cause;
  assign busy          = r_busy;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses, completions checked by a
// scoreboard monitor against hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        busy;

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .rdata(rdata), .done(done), .fault(fault),
    .fault_cause(fault_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        fault;
    logic [1:0]  cause;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic chk_rd, input logic flt,
                      input logic [1:0] cause, input int dcyc);
    exp_t x;
    x.rdata = rd; x.chk_rdata = chk_rd; x.fault = flt; x.cause = cause; x.done_cyc = dcyc;
    q.push_back(x);
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("done_fault", {31'd0, fault}, {31'd0, e.fault});
        chk("done_cause", {30'd0, fault_cause}, {30'd0, e.cause});
        if (e.chk_rdata) chk("done_rdata", rdata, e.rdata);
      end
    end
  end

  // Load with ready high and response one cycle after accept: done at N+3.
  task automatic load_fast(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] expd);
    int n;
    mem_req_ready = 1'b1;
    start = 1'b1; is_store = 1'b0; funct3 = f3; addr = a;
    n = cyc;
    push(expd, 1'b1, 1'b0, 2'd0, n + 3);
    tick();
    start = 1'b0;
    chk("ld_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("ld_addr", mem_addr, {a[31:2], 2'b00});
    chk("ld_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    tick();
    chk("ld_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = word;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
  endtask

  // Store with ready high: accept at N+1, done at N+2.
  task automatic store_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] strb, input logic [31:0] wd);
    int n;
    mem_req_ready = 1'b1;
    start = 1'b1; is_store = 1'b1; funct3 = f3; addr = a; wdata = d;
    n = cyc;
    push('0, 1'b0, 1'b0, 2'd0, n + 2);
    tick();
    start = 1'b0;
    chk("st_ctrl", {26'd0, mem_req_valid, mem_we, mem_wstrb}, {26'd0, 2'b11, strb});
    chk("st_addr", mem_addr, {a[31:2], 2'b00});
    chk("st_wdata", mem_wdata, wd);
    tick();
    tick();
  endtask

  // Rejected access: done+fault at N+1, no request ever raised.
  task automatic fault_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [1:0] cause);
    int n;
    mem_req_ready = 1'b1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a;
    n = cyc;
    push('0, 1'b0, 1'b1, cause, n + 1);
    tick();
    start = 1'b0;
    chk("flt_no_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_ctrl", {21'd0, busy, done, fault, mem_req_valid, mem_we, mem_wstrb, fault_cause}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Loads: sign/zero extension at various lane offsets
    load_fast(3'd0, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    load_fast(3'd4, 32'h0000_0101, 32'h0000_F500, 32'h0000_00F5);
    load_fast(3'd1, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001);
    load_fast(3'd2, 32'h0000_0008, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Stores: halfword and byte lane steering
    store_fast(3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_fast(3'd0, 32'h0000_0201, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);

    // Backpressure: LHU with ready low for 5 cycles
    mem_req_ready = 1'b0;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd5; addr = 32'h10;
    n = cyc;
    push(32'h0000_9ABC, 1'b1, 1'b0, 2'd0, n + 8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_ctrl", {26'd0, mem_req_valid, mem_we, mem_wstrb}, 32'h20);
      chk("bp_stall_addr", mem_addr, 32'h10);
      tick();
    end
    chk("bp_still_valid", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("bp_single_accept", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_9ABC;
    tick();
    mem_rsp_valid = 1'b0;
    tick();

    // Rejected accesses: legality is checked before alignment
    fault_req(1'b0, 3'd2, 32'h6, 2'd1);
    fault_req(1'b1, 3'd4, 32'h0, 2'd2);
    fault_req(1'b0, 3'd7, 32'h1, 2'd2);
    fault_req(1'b0, 3'd1, 32'h5, 2'd1);

    // Timeout: ready held low, abort 8 cycles after REQ entry
    mem_req_ready = 1'b0;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
    n = cyc;
    push('0, 1'b0, 1'b1, 2'd3, n + 9);
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("tmo_valid_before", {31'd0, mem_req_valid}, 32'd1);
    tick();
    chk("tmo_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("tmo_late_rsp_ignored", rdata, 32'h0000_9ABC);

    // Start while busy and start during the done pulse are both ignored
    mem_req_ready = 1'b0;
    start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h300; wdata = 32'h1122_3344;
    n = cyc;
    push('0, 1'b0, 1'b0, 2'd0, n + 3);
    tick();
    is_store = 1'b0; addr = 32'h400;
    chk("sw_ctrl", {26'd0, mem_req_valid, mem_we, mem_wstrb}, 32'h3F);
    chk("sw_wdata", mem_wdata, 32'h1122_3344);
    tick();
    start = 1'b0;
    chk("busy_start_ignored", mem_addr, 32'h300);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin_start_ignored", {30'd0, busy, mem_req_valid}, 32'd0);
    tick();

    // Reset during WAIT aborts without a done pulse
    mem_req_ready = 1'b1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h20;
    tick();
    start = 1'b0;
    tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_req_ready = 1'b0;
    chk("rst_abort_ctrl", {29'd0, busy, done, mem_req_valid}, 32'd0);
    chk("rst_abort_rdata", rdata, 32'd0);
    tick();
    chk("rst_abort_no_done", {31'd0, done}, 32'd0);

    // Spurious response in IDLE leaves rdata untouched
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    chk("idle_rsp_ignored", rdata, 32'd0);

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
